uart_tx_frame: RTL and testbench

UART transmit engine; the counterpart of the UART RX path (start/data/parity/stop checking).
- Accepts a parallel byte with a valid strobe and serializes it as: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Runs on the TX bit clock, one bit per clock cycle. Clock division is done upstream by the system clock-divider.
- Sits between the TX-side async FIFO/pulse-gen and the serial pad.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_serializer.sv | 47 ++++
 rtl/uart_tx_frame.sv | 112 +++++++++++
 tb/tb_uart_tx_frame.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity selection and line levels.
// Used by both the TX engine and the RX-side checkers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the latched data word and the data-bit counter for the TX engine.
// Provides a look-ahead bit so the top level can keep TX_OUT registered.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  next_bit_o,
    output logic                  done_o
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // Bit that will be on the line once the pending load/shift has taken effect.
    assign next_bit_o = data_q[cnt_d];
    assign done_o     = (cnt_q == CW'(DATA_WIDTH - 1));
    assign data_o     = data_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: one bit per CLK, frame = start, data LSB first,
// optional parity, one stop bit. TX_OUT and Busy come straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    uart_state_e           state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_en_q, par_typ_q;
    logic                  load_en, shift_en;
    logic                  next_bit, data_done, parity_bit;
    logic [DATA_WIDTH-1:0] data_lat;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (load_en),
        .shift_i    (shift_en),
        .data_i     (P_DATA),
        .data_o     (data_lat),
        .next_bit_o (next_bit),
        .done_o     (data_done)
    );

    assign parity_bit = (^data_lat) ^ par_typ_q;

    // Outputs are decided from the transition so they appear on the same edge as the new state.
    always_comb begin
        state_d  = state_q;
        tx_d     = STOP_BIT;
        busy_d   = 1'b0;
        load_en  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d = START;
                    load_en = 1'b1;
                    tx_d    = START_BIT;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = next_bit;
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (data_done) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_bit;
                    end else begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    shift_en = 1'b1;
                    tx_d     = next_bit;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
                busy_d  = 1'b1;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tx_q      <= STOP_BIT;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (load_en) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus queues hand-written frame strings,
// a monitor captures TX_OUT over each Busy window and compares.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int    checks = 0;
    int    failures = 0;
    string exp_q[$];
    int    last_gap = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        string cap;
        bit    in_frame;
        int    idle_cnt;
        string exp;
        cap = "";
        in_frame = 1'b0;
        idle_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                cap = "";
                in_frame = 1'b0;
                idle_cnt = 0;
            end else if (Busy) begin
                if (!in_frame) begin
                    last_gap = idle_cnt;
                    in_frame = 1'b1;
                end
                idle_cnt = 0;
                cap = {cap, (TX_OUT ? "1" : "0")};
            end else begin
                idle_cnt++;
                checks++;
                if (TX_OUT !== 1'b1) begin
                    failures++;
                    $display("FAIL idle_line: TX_OUT=%b required 1 at %0t", TX_OUT, $time);
                end
                if (in_frame) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame: got %s, no frame expected", cap);
                    end else begin
                        exp = exp_q.pop_front();
                        if (cap != exp) begin
                            failures++;
                            $display("FAIL frame: got %s required %s", cap, exp);
                        end else begin
                            $display("frame ok: %s", cap);
                        end
                    end
                    cap = "";
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input string exp, input bit push);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        Data_Valid = 1'b1;
        if (push) exp_q.push_back(exp);
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int maxc, input string name);
        for (int i = 0; i < maxc; i++) begin
            if (Busy === lvl) return;
            @(posedge CLK); #1;
        end
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for Busy=%b", name, lvl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check_bit("reset_tx", TX_OUT, 1'b1);
        check_bit("reset_busy", Busy, 1'b0);
        @(posedge CLK); #3;
        RST = 1'b1;
        @(posedge CLK); #1;

        // 1: idle for 20 cycles, monitor checks the line
        repeat (20) @(posedge CLK);
        #1;
        check_bit("idle_busy", Busy, 1'b0);

        // 2: A5, even parity
        send(8'hA5, 1'b1, 1'b0, "01010010101", 1'b1);
        check_bit("accept_busy", Busy, 1'b1);
        check_bit("accept_start", TX_OUT, 1'b0);
        wait_busy(1'b0, 20, "t2_end");
        @(posedge CLK); #1;

        // 3: 00 odd parity, then FF no parity
        send(8'h00, 1'b1, 1'b1, "00000000011", 1'b1);
        wait_busy(1'b0, 20, "t3a_end");
        @(posedge CLK); #1;
        send(8'hFF, 1'b0, 1'b0, "0111111111", 1'b1);
        wait_busy(1'b0, 20, "t3b_end");
        @(posedge CLK); #1;

        // 4: Data_Valid held, data changed mid-frame
        P_DATA = 8'hA5;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        Data_Valid = 1'b1;
        exp_q.push_back("0101001011");
        @(posedge CLK); #1;
        repeat (3) @(posedge CLK);
        #1;
        P_DATA = 8'h3C;
        exp_q.push_back("0001111001");
        wait_busy(1'b0, 20, "t4_first_end");
        wait_busy(1'b1, 5, "t4_second_start");
        Data_Valid = 1'b0;
        wait_busy(1'b0, 20, "t4_second_end");
        @(posedge CLK); #1;
        checks++;
        if (last_gap != 1) begin
            failures++;
            $display("FAIL gap: got %0d idle cycles required 1", last_gap);
        end
        repeat (3) @(posedge CLK);
        #1;

        // 5: reset during 4th data bit, frame abandoned
        send(8'hA5, 1'b0, 1'b0, "", 1'b0);
        repeat (4) @(posedge CLK);
        #2;
        check_bit("pre_reset_bit3", TX_OUT, 1'b0);
        RST = 1'b0;
        #1;
        check_bit("async_reset_tx", TX_OUT, 1'b1);
        check_bit("async_reset_busy", Busy, 1'b0);
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check_bit("post_reset_busy", Busy, 1'b0);
        send(8'h3C, 1'b1, 1'b1, "00011110011", 1'b1);
        wait_busy(1'b0, 20, "t5_end");
        @(posedge CLK); #1;

        // 6: extra Data_Valid pulse during frame is ignored
        send(8'hA5, 1'b1, 1'b1, "01010010111", 1'b1);
        @(posedge CLK); #1;
        P_DATA = 8'hFF;
        Data_Valid = 1'b1;
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        wait_busy(1'b0, 20, "t6_end");
        repeat (15) @(posedge CLK);
        #1;
        check_bit("t6_no_second_frame", Busy, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_frames: got %0d left required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
